// File: rtl/cra_sbr_stack_if.sv
// Bus bundle for the CRA microcode subroutine stack: push/pop controls in, stack status and data out.
interface cra_sbr_stack_if #(
    parameter int unsigned ADR_W = 11,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned SP_W = $clog2(DEPTH);

    logic              CALL;
    logic              FORCE_1777;
    logic              RET;
    logic [ADR_W-1:0]  PUSH_ADR;
    logic              CLR_ERR;
    logic [SP_W-1:0]   DIAG_IDX;

    logic [ADR_W-1:0]  SBR_RET;
    logic [SP_W-1:0]   SP;
    logic [SP_W:0]     COUNT;
    logic              EMPTY;
    logic              FULL;
    logic              OVF;
    logic              UNF;
    logic [ADR_W-1:0]  DIAG_DATA;
    logic              PAR_ERR;

    modport master (
        output CALL, FORCE_1777, RET, PUSH_ADR, CLR_ERR, DIAG_IDX,
        input  SBR_RET, SP, COUNT, EMPTY, FULL, OVF, UNF, DIAG_DATA, PAR_ERR
    );

    modport slave (
        input  CALL, FORCE_1777, RET, PUSH_ADR, CLR_ERR, DIAG_IDX,
        output SBR_RET, SP, COUNT, EMPTY, FULL, OVF, UNF, DIAG_DATA, PAR_ERR
    );
endinterface

// File: rtl/cra_sbr_stack.sv
// Circular CALL/RETURN stack for the CRAM address path with occupancy and sticky error tracking.
// Optional per-entry odd parity is enabled by defining CRA_SBR_STACK_PARITY_EN.
module cra_sbr_stack #(
    parameter int unsigned ADR_W = 11,
    parameter int unsigned DEPTH = 16
) (
    input logic            clk,
    input logic            RESET_N,
    cra_sbr_stack_if.slave bus
);
    localparam int unsigned SP_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W = SP_W + 1;
`ifdef CRA_SBR_STACK_PARITY_EN
    localparam int unsigned ENT_W = ADR_W + 1;
`else
    localparam int unsigned ENT_W = ADR_W;
`endif

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ADR_W-1:0] sbr_ret_q, sbr_ret_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             par_err_q, par_err_d;

    logic             push;
    logic             pop;
    logic [SP_W-1:0]  sp_dec;
    logic [ENT_W-1:0] rd_ent;
    logic [ENT_W-1:0] wr_ent;

    // Push takes priority; a RET coinciding with a push is dropped.
    always_comb begin
        push      = bus.CALL | bus.FORCE_1777;
        pop       = bus.RET & ~push;
        sp_dec    = sp_q - SP_W'(1);
        rd_ent    = mem_q[sp_dec];
`ifdef CRA_SBR_STACK_PARITY_EN
        wr_ent    = {~^bus.PUSH_ADR, bus.PUSH_ADR};
`else
        wr_ent    = bus.PUSH_ADR;
`endif
        mem_d     = mem_q;
        sp_d      = sp_q;
        count_d   = count_q;
        sbr_ret_d = sbr_ret_q;
        par_err_d = par_err_q;
        ovf_d     = bus.CLR_ERR ? 1'b0 : ovf_q;
        unf_d     = bus.CLR_ERR ? 1'b0 : unf_q;

        if (push) begin
            mem_d[sp_q] = wr_ent;
            sp_d        = sp_q + SP_W'(1);
            if (count_q == CNT_W'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            // Empty pop still moves SP and returns whatever stale entry sits there.
            sbr_ret_d = rd_ent[ADR_W-1:0];
            sp_d      = sp_dec;
`ifdef CRA_SBR_STACK_PARITY_EN
            par_err_d = rd_ent[ADR_W] != (^rd_ent[ADR_W-1:0] ^ 1'b1);
`endif
            if (count_q == CNT_W'(0)) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end

        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q      <= '0;
            count_q   <= '0;
            sbr_ret_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            sp_q      <= sp_d;
            count_q   <= count_d;
            sbr_ret_q <= sbr_ret_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            par_err_q <= par_err_d;
        end
    end

    assign bus.SBR_RET   = sbr_ret_q;
    assign bus.SP        = sp_q;
    assign bus.COUNT     = count_q;
    assign bus.EMPTY     = empty_q;
    assign bus.FULL      = full_q;
    assign bus.OVF       = ovf_q;
    assign bus.UNF       = unf_q;
    assign bus.DIAG_DATA = mem_q[bus.DIAG_IDX][ADR_W-1:0];
`ifdef CRA_SBR_STACK_PARITY_EN
    assign bus.PAR_ERR   = par_err_q;
`else
    assign bus.PAR_ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_cra_sbr_stack.sv
// Directed bench for cra_sbr_stack: push/pop order, push priority, wrap, underflow, async reset.
module tb_cra_sbr_stack;
    localparam int unsigned ADR_W = 11;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic RESET_N;
    int   n_checks;
    int   n_fail;

    cra_sbr_stack_if #(.ADR_W(ADR_W), .DEPTH(DEPTH)) bus ();

    cra_sbr_stack #(.ADR_W(ADR_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every operation spans one posedge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.CALL       = 1'b0;
        bus.FORCE_1777 = 1'b0;
        bus.RET        = 1'b0;
        bus.CLR_ERR    = 1'b0;
    endtask

    task automatic push(input logic [ADR_W-1:0] adr);
        bus.CALL     = 1'b1;
        bus.PUSH_ADR = adr;
        tick();
    endtask

    task automatic pop();
        bus.RET = 1'b1;
        tick();
    endtask

    task automatic reset_pulse();
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        RESET_N        = 1'b0;
        bus.CALL       = 1'b0;
        bus.FORCE_1777 = 1'b0;
        bus.RET        = 1'b0;
        bus.CLR_ERR    = 1'b0;
        bus.PUSH_ADR   = '0;
        bus.DIAG_IDX   = '0;
        #23;
        check("rst_sp",      32'(bus.SP), 0);
        check("rst_count",   32'(bus.COUNT), 0);
        check("rst_sbr_ret", 32'(bus.SBR_RET), 0);
        check("rst_empty",   32'(bus.EMPTY), 1);
        check("rst_full",    32'(bus.FULL), 0);
        check("rst_ovf_unf", 32'({bus.OVF, bus.UNF}), 0);
        check("rst_par_err", 32'(bus.PAR_ERR), 0);
        RESET_N = 1'b1;

        // Basic LIFO order
        push(11'o0123);
        check("t1_sp1", 32'(bus.SP), 1);
        push(11'o0456);
        check("t1_sp2", 32'(bus.SP), 2);
        check("t1_cnt2", 32'(bus.COUNT), 2);
        pop();
        check("t1_ret1", 32'(bus.SBR_RET), 32'o0456);
        check("t1_sp3", 32'(bus.SP), 1);
        pop();
        check("t1_ret2", 32'(bus.SBR_RET), 32'o0123);
        check("t1_sp4", 32'(bus.SP), 0);
        check("t1_empty", 32'(bus.EMPTY), 1);
        check("t1_errs", 32'({bus.OVF, bus.UNF}), 0);

        // Push beats a simultaneous RET
        bus.RET = 1'b1;
        push(11'o0777);
        check("t2_sp", 32'(bus.SP), 1);
        check("t2_ret_hold", 32'(bus.SBR_RET), 32'o0123);
        check("t2_cnt", 32'(bus.COUNT), 1);
        bus.RET        = 1'b1;
        bus.FORCE_1777 = 1'b1;
        bus.PUSH_ADR   = 11'o0111;
        tick();
        check("t2_f_sp", 32'(bus.SP), 2);
        check("t2_f_ret_hold", 32'(bus.SBR_RET), 32'o0123);
        bus.DIAG_IDX = 4'd1;
        #1;
        check("t2_diag1", 32'(bus.DIAG_DATA), 32'o0111);
        pop();
        check("t2_pop1", 32'(bus.SBR_RET), 32'o0111);
        pop();
        check("t2_pop2", 32'(bus.SBR_RET), 32'o0777);
        check("t2_empty", 32'(bus.EMPTY), 1);

        // Fill, overflow, wrap, drain
        reset_pulse();
        for (int i = 0; i < 17; i++) begin
            push(ADR_W'(i));
            if (i == 14) check("t3_notfull15", 32'(bus.FULL), 0);
            if (i == 15) begin
                check("t3_full16", 32'(bus.FULL), 1);
                check("t3_cnt16", 32'(bus.COUNT), 16);
                check("t3_noovf16", 32'(bus.OVF), 0);
            end
        end
        check("t3_ovf", 32'(bus.OVF), 1);
        check("t3_sp", 32'(bus.SP), 1);
        check("t3_cnt", 32'(bus.COUNT), 16);
        bus.DIAG_IDX = 4'd0;
        #1;
        check("t3_entry0", 32'(bus.DIAG_DATA), 16);
        pop();
        check("t3_first_pop", 32'(bus.SBR_RET), 16);
        for (int i = 1; i < 16; i++) pop();
        check("t3_last_pop", 32'(bus.SBR_RET), 1);
        check("t3_drain_cnt", 32'(bus.COUNT), 0);
        check("t3_drain_sp", 32'(bus.SP), 1);
        check("t3_drain_empty", 32'(bus.EMPTY), 1);
        check("t3_ovf_sticky", 32'(bus.OVF), 1);
        check("t3_unf_clear", 32'(bus.UNF), 0);
        bus.CLR_ERR = 1'b1;
        tick();
        check("t3_ovf_clr", 32'(bus.OVF), 0);

        // Underflow from reset, clear, and set-wins-over-clear
        reset_pulse();
        pop();
        check("t4_unf", 32'(bus.UNF), 1);
        check("t4_sp", 32'(bus.SP), 15);
        check("t4_cnt", 32'(bus.COUNT), 0);
        check("t4_ret_stale", 32'(bus.SBR_RET), 0);
        bus.CLR_ERR = 1'b1;
        tick();
        check("t4_unf_clr", 32'(bus.UNF), 0);
        bus.CLR_ERR = 1'b1;
        pop();
        check("t4_unf_set_wins", 32'(bus.UNF), 1);
        check("t4_sp2", 32'(bus.SP), 14);

        // Asynchronous reset mid-sequence
        reset_pulse();
        push(11'o0301);
        push(11'o0302);
        push(11'o0303);
        pop();
        check("t5_pre_ret", 32'(bus.SBR_RET), 32'o0303);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t5_async_sp", 32'(bus.SP), 0);
        check("t5_async_cnt", 32'(bus.COUNT), 0);
        check("t5_async_ret", 32'(bus.SBR_RET), 0);
        check("t5_async_empty", 32'(bus.EMPTY), 1);
        RESET_N = 1'b1;
        push(11'o0042);
        bus.DIAG_IDX = 4'd0;
        #1;
        check("t5_diag0", 32'(bus.DIAG_DATA), 32'o0042);
        bus.DIAG_IDX = 4'd1;
        #1;
        check("t5_diag1_cleared", 32'(bus.DIAG_DATA), 0);
        check("t5_sp", 32'(bus.SP), 1);

        // Clean push/pop never flags parity
        push(11'o1234);
        pop();
        check("t6_ret", 32'(bus.SBR_RET), 32'o1234);
        check("t6_par_err", 32'(bus.PAR_ERR), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
